// File: rtl/dac_env_pkg.sv
// rtl/dac_env_pkg.sv - shared types, constants and clamp helper for dac_envelope_stage
package dac_env_pkg;

    localparam int AXIS_TDATA_WIDTH = 16;
    localparam int DAC_WIDTH        = 14;
    localparam int STEP_WIDTH       = 17;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } env_state_t;

    localparam logic [STEP_WIDTH-1:0] ENV_ONE = 17'h10000;
    localparam logic signed [17:0]    DAC_MAX = 18'sd8191;
    localparam logic signed [17:0]    DAC_MIN = -18'sd8191;

    // Symmetric clamp: -8192 is deliberately excluded from the DAC range.
    function automatic logic signed [17:0] clamp_dac(input logic signed [17:0] v);
        return (v > DAC_MAX) ? DAC_MAX : ((v < DAC_MIN) ? DAC_MIN : v);
    endfunction

endpackage

// File: rtl/dac_env_ramp.sv
// rtl/dac_env_ramp.sv - envelope state machine with saturating env register, stepped per accepted sample
module dac_env_ramp
    import dac_env_pkg::*;
(
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  accept,
    input  logic                  cfg_enable,
    input  logic [STEP_WIDTH-1:0] cfg_step,
    output logic [STEP_WIDTH-1:0] env,
    output logic [1:0]            env_state,
    output logic                  ramp_done
);

    env_state_t            state, state_nxt;
    logic [STEP_WIDTH-1:0] env_nxt;
    logic                  done_nxt;
    logic [STEP_WIDTH:0]   up_sum;
    logic                  step_zero;

    assign up_sum    = {1'b0, env} + {1'b0, cfg_step};
    assign step_zero = (cfg_step == '0);
    assign env_state = state;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= IDLE;
            env       <= '0;
            ramp_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            env       <= env_nxt;
            ramp_done <= done_nxt;
        end
    end

    // Enable changes act every cycle; env only moves on an accepted sample.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                env_nxt = '0;
                if (cfg_enable) state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (!cfg_enable) begin
                    state_nxt = RAMP_DOWN;
                end else if (accept && (step_zero || up_sum >= {1'b0, ENV_ONE})) begin
                    env_nxt   = ENV_ONE;
                    state_nxt = ON;
                    done_nxt  = 1'b1;
                end else if (accept) begin
                    env_nxt = up_sum[STEP_WIDTH-1:0];
                end
            end
            ON: begin
                env_nxt = ENV_ONE;
                if (!cfg_enable) state_nxt = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (cfg_enable) begin
                    state_nxt = RAMP_UP;
                end else if (accept && (step_zero || env <= cfg_step)) begin
                    env_nxt   = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (accept) begin
                    env_nxt = env - cfg_step;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/dac_envelope_stage.sv
// rtl/dac_envelope_stage.sv - envelope scale, DC offset and DAC clamp; DAC_ENV_ROUND_EN selects round-half-up scaling
module dac_envelope_stage
    import dac_env_pkg::*;
(
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        cfg_enable,
    input  logic [STEP_WIDTH-1:0]       cfg_step,
    input  logic [DAC_WIDTH-1:0]        cfg_offset,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [1:0]                  env_state,
    output logic                        ramp_done
);

    logic                  adv;
    logic                  accept;
    logic [STEP_WIDTH-1:0] env;

    logic signed [33:0]    prod;
    logic signed [33:0]    prod_r;
    logic [15:0]           unused_prod_lsbs;
    logic                  s1_valid;
    logic signed [17:0]    s1_scaled;

    logic signed [17:0]    sum;
    logic signed [17:0]    clamped;
    logic [1:0]            unused_clamp_msbs;

    assign adv           = m_axis_tready | ~m_axis_tvalid;
    assign s_axis_tready = adv;
    assign accept        = s_axis_tvalid & adv;

    dac_env_ramp u_ramp (
        .clk        (clk),
        .aresetn    (aresetn),
        .accept     (accept),
        .cfg_enable (cfg_enable),
        .cfg_step   (cfg_step),
        .env        (env),
        .env_state  (env_state),
        .ramp_done  (ramp_done)
    );

    assign prod = $signed({{18{s_axis_tdata[AXIS_TDATA_WIDTH-1]}}, s_axis_tdata})
                * $signed({17'b0, env});
`ifdef DAC_ENV_ROUND_EN
    assign prod_r = prod + 34'sh8000;
`else
    assign prod_r = prod;
`endif
    assign unused_prod_lsbs = prod_r[15:0];

    assign sum               = s1_scaled + {{(18-DAC_WIDTH){cfg_offset[DAC_WIDTH-1]}}, cfg_offset};
    assign clamped           = clamp_dac(sum);
    assign unused_clamp_msbs = clamped[17:16];

    // Single stall signal: both stages move together or hold together.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            s1_valid      <= 1'b0;
            s1_scaled     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (adv) begin
            s1_valid      <= accept;
            if (accept) s1_scaled <= prod_r[33:16];
            m_axis_tvalid <= s1_valid;
            if (s1_valid) m_axis_tdata <= clamped[15:0];
        end
    end

endmodule

// File: tb/tb_dac_envelope_stage.sv
// tb/tb_dac_envelope_stage.sv - randomized scoreboard bench for dac_envelope_stage
module tb_dac_envelope_stage;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [15:0] s_axis_tdata;
    logic        cfg_enable;
    logic [16:0] cfg_step;
    logic [13:0] cfg_offset;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [15:0] m_axis_tdata;
    logic [1:0]  env_state;
    logic        ramp_done;

    always #5 clk = ~clk;

    dac_envelope_stage dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .cfg_enable    (cfg_enable),
        .cfg_step      (cfg_step),
        .cfg_offset    (cfg_offset),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .env_state     (env_state),
        .ramp_done     (ramp_done)
    );

    localparam int ONE = 65536;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int out_log[$];
    int data_int;
    int off_int;
    int m_mode;
    int m_env;
    int m_done;
    int rd_count;
    bit last_acc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_out(input int d, input int e, input int off);
        longint p;
        int s;
        p = longint'(d) * longint'(e);
`ifdef DAC_ENV_ROUND_EN
        p = p + 64'sd32768;
`endif
        s = int'(p >>> 16) + off;
        if (s > 8191) s = 8191;
        if (s < -8191) s = -8191;
        return s;
    endfunction

    // Envelope rules in plain integers: mode 0 idle, 1 up, 2 on, 3 down.
    task automatic model_step(input bit acc, input bit en, input int step);
        m_done = 0;
        case (m_mode)
            0: begin
                m_env = 0;
                if (en) m_mode = 1;
            end
            1: begin
                if (!en) m_mode = 3;
                else if (acc) begin
                    m_env = (step == 0) ? ONE : ((m_env + step > ONE) ? ONE : m_env + step);
                    if (m_env == ONE) begin m_mode = 2; m_done = 1; end
                end
            end
            2: begin
                m_env = ONE;
                if (!en) m_mode = 3;
            end
            default: begin
                if (en) m_mode = 1;
                else if (acc) begin
                    m_env = (step == 0) ? 0 : ((m_env - step < 0) ? 0 : m_env - step);
                    if (m_env == 0) begin m_mode = 0; m_done = 1; end
                end
            end
        endcase
    endtask

    task automatic set_data(input int d);
        data_int = d;
        s_axis_tdata = 16'(d);
    endtask

    task automatic set_off(input int o);
        off_int = o;
        cfg_offset = 14'(o);
    endtask

    task automatic tick();
        #1;
        last_acc = aresetn && s_axis_tvalid && s_axis_tready;
        if (!aresetn) begin
            m_mode = 0;
            m_env = 0;
            m_done = 0;
            exp_q.delete();
        end else begin
            if (last_acc) exp_q.push_back(ref_out(data_int, m_env, off_int));
            model_step(last_acc, cfg_enable, int'(cfg_step));
        end
        @(posedge clk);
        @(negedge clk);
        check("env_state", int'(env_state), m_mode);
        check("ramp_done", int'(ramp_done), m_done);
        if (ramp_done) rd_count++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        run(4);
    endtask

    logic [15:0] held;
    bit          holding = 1'b0;

    always @(negedge clk) begin
        #2;
        if (!aresetn) begin
            holding = 1'b0;
        end else begin
            if (holding) begin
                check("stall_tdata", int'(m_axis_tdata), int'(held));
                check("stall_tvalid", int'(m_axis_tvalid), 1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_log.push_back(int'($signed(m_axis_tdata)));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected none", $signed(m_axis_tdata));
                end else begin
                    check("sample", int'($signed(m_axis_tdata)), exp_q.pop_front());
                end
            end
            holding = m_axis_tvalid && !m_axis_tready;
            held = m_axis_tdata;
        end
    end

    initial begin
        int ramp_exp[4];
        int first_nz;
        int idx;
        int cyc;
`ifdef DAC_ENV_ROUND_EN
        ramp_exp = '{2048, 4096, 6143, 8191};
`else
        ramp_exp = '{2047, 4095, 6143, 8191};
`endif
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cfg_enable = 1'b0;
        cfg_step = 17'h04000;
        set_data(0);
        set_off(0);
        m_mode = 0;
        m_env = 0;
        rd_count = 0;
        run(2);
        check("rst_tvalid", int'(m_axis_tvalid), 0);
        check("rst_tdata", int'(m_axis_tdata), 0);
        check("rst_s_tready", int'(s_axis_tready), 1);

        // Ramp up with a constant full-scale input.
        aresetn = 1'b1;
        out_log.delete();
        set_data(8191);
        s_axis_tvalid = 1'b1;
        cfg_enable = 1'b1;
        run(10);
        check("rampup_done_count", rd_count, 1);
        first_nz = -1;
        for (int i = 0; i < out_log.size(); i++)
            if (first_nz < 0 && out_log[i] != 0) first_nz = i;
        for (int i = 0; i < 4; i++)
            check("rampup_seq", (first_nz >= 0 && first_nz + i < out_log.size()) ? out_log[first_nz + i] : -99999, ramp_exp[i]);

        // Ramp down, then reverse mid-ramp.
        cfg_enable = 1'b0;
        run(3);
        cfg_enable = 1'b1;
        run(8);

        // Saturation at both rails and the IDLE DC level.
        drain();
        set_off(100);
        s_axis_tvalid = 1'b1;
        set_data(8191);
        run(4);
        drain();
        set_off(-100);
        s_axis_tvalid = 1'b1;
        set_data(-8192);
        run(4);
        drain();
        cfg_enable = 1'b0;
        cfg_step = 17'h0;
        s_axis_tvalid = 1'b1;
        run(3);
        drain();
        set_off(-8192);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_data(int'($signed(16'($urandom))));
            tick();
        end

        // Back-pressure with a counting input while ON.
        drain();
        set_off(0);
        cfg_enable = 1'b1;
        s_axis_tvalid = 1'b1;
        run(3);
        idx = 0;
        cyc = 0;
        while (idx < 1000 && cyc < 6000) begin
            set_data(idx);
            m_axis_tready = $urandom_range(0, 1) == 1;
            tick();
            if (last_acc) idx++;
            cyc++;
        end
        check("bp_all_accepted", idx, 1000);

        // Random enable toggles, steps and handshakes.
        drain();
        set_off(int'($urandom_range(0, 4000)) - 2000);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) cfg_enable = ~cfg_enable;
            cfg_step = ($urandom_range(0, 7) == 0) ? 17'h0 : 17'($urandom_range(1, 24576));
            set_data(int'($signed(16'($urandom))));
            s_axis_tvalid = $urandom_range(0, 3) != 0;
            m_axis_tready = $urandom_range(0, 4) < 3;
            tick();
        end

        // Reset in the middle of a ramp with samples in flight.
        drain();
        cfg_enable = 1'b0;
        cfg_step = 17'h0;
        s_axis_tvalid = 1'b1;
        run(3);
        cfg_enable = 1'b1;
        cfg_step = 17'h00100;
        set_data(5000);
        run(10);
        m_axis_tready = 1'b0;
        run(2);
        aresetn = 1'b0;
        tick();
        check("midrst_tvalid", int'(m_axis_tvalid), 0);
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        run(20);

        s_axis_tvalid = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        run(2);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_envelope_stage.md
# dac_envelope_stage

Downstream stage of the signal generator: consumes its signed AXI-Stream sample stream, applies a programmable linear ramp-up/ramp-down envelope on enable/disable, adds a DC offset, saturates to the symmetric DAC range ±8191, and emits the result on a back-pressured AXI-Stream toward the DAC interface. The envelope removes output steps when a channel is switched on or off mid-waveform.

## Interface
- AXIS_TDATA_WIDTH, 16, sample width in and out, signed two's complement.
- DAC_WIDTH, 14, DAC range; output clamped to ±(2^(DAC_WIDTH-1)-1).
- STEP_WIDTH, 17, width of envelope step and envelope register; full scale is 0x10000.

- clk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  input sample accepted when high with tvalid.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  signed input sample.
- cfg_enable  in  1  level; 1 requests output on, 0 requests output off.
- cfg_step  in  STEP_WIDTH  envelope increment per accepted sample, unsigned; 0 = instant switch.
- cfg_offset  in  DAC_WIDTH  signed DC offset added after scaling.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  signed result, sign-extended from DAC_WIDTH.
- env_state  out  2  current state: 0 IDLE, 1 RAMP_UP, 2 ON, 3 RAMP_DOWN.
- ramp_done  out  1  one-cycle pulse on entering ON or IDLE from a ramp.

## Operation
- Pipeline advance: adv = m_axis_tready | ~m_axis_tvalid. s_axis_tready = adv. A sample is accepted when s_axis_tvalid & adv.
- Stage 1, on accept: prod = s_axis_tdata (signed) × env (unsigned, STEP_WIDTH bits), 33-bit signed; scaled = prod >>> 16 (arithmetic).
- Stage 2: sum = scaled + sign-extended cfg_offset (18-bit); clamp to [-8191, +8191]; -8192 and below → -8191.
- Each accepted sample uses the env value before that sample's update.
- State machine (env updates only on accepted samples; state checks on cfg_enable every cycle):
  - IDLE: env = 0. cfg_enable=1 → RAMP_UP.
  - RAMP_UP: per accept, env = min(env + cfg_step, 0x10000); on reaching 0x10000 → ON, pulse ramp_done. cfg_enable=0 → RAMP_DOWN from current env, no jump. cfg_step=0 → env = 0x10000, ON next cycle.
  - ON: env = 0x10000. cfg_enable=0 → RAMP_DOWN.
  - RAMP_DOWN: per accept, env = max(env - cfg_step, 0); on reaching 0 → IDLE, pulse ramp_done. cfg_enable=1 → RAMP_UP from current env. cfg_step=0 → env = 0, IDLE.
- Transition on a cycle with an accepted sample: the sample uses the old env; the new state's update starts with the next accept.
- In IDLE the output equals the clamped cfg_offset, not silence, so the DAC holds its DC level.
- cfg_step and cfg_offset are sampled per accepted sample or stage advance. Changing them mid-ramp is legal.

## Timing
- Latency: 2 cycles from acceptance to m_axis_tvalid when unstalled. Throughput is 1 sample per cycle.
- Stall: while m_axis_tvalid & ~m_axis_tready, both stages, env and m_axis_tdata hold. No sample is lost or duplicated.
- Reset: m_axis_tvalid 0, m_axis_tdata 0, s_axis_tready 1 on the first cycle after reset, env 0, env_state IDLE, ramp_done 0, pipeline valid bits 0.
- Reset mid-ramp aborts to IDLE with env 0. In-flight samples are discarded.

## Configuration
- DAC_ENV_ROUND_EN defined: stage 1 adds 0x8000 to prod before >>>16, giving round-half-up.
- DAC_ENV_ROUND_EN undefined: plain truncation toward −∞. Latency is identical in both builds.

## Structure
- Package dac_env_pkg holds:
  - state enum env_state_t {IDLE, RAMP_UP, ON, RAMP_DOWN}
  - ENV_ONE = 17'h10000
  - DAC_MAX = 8191, DAC_MIN = -8191
- Sub-module dac_env_ramp: state machine plus env register with saturating add/subtract, enabled by the accept strobe. The top level holds the two datapath stages and the handshake.

## Test plan
- Ramp up, truncation build: cfg_offset 0, cfg_step 0x4000, constant input 8191, tready 1, enable rises → outputs 0, 2047, 4095, 6143, then 8191 onward; ramp_done pulses once on entering ON.
- Same with DAC_ENV_ROUND_EN: outputs 0, 2048, 4096, 6143, 8191.
- Ramp down with reversal: from ON, step 0x4000, disable → 8191, 6143; enable re-asserted → env climbs from 0x8000 without a jump; no ramp_done until ON.
- Saturation: ON, offset +100, input 8191 → 8191; offset -100, input -8192 → -8191; IDLE with offset -8192 → -8191.
- Back-pressure: random m_axis_tready at 50%, input ramp 0..999 in ON, offset 0 → output sequence 0..999 exact, with no gaps or duplicates, and tdata stable while stalled.
- Reset mid-RAMP_UP: aresetn low 1 cycle → next cycle m_axis_tvalid 0, env_state IDLE; after release with enable high, ramp restarts at env 0.
